// File: rtl/panda_risc_v_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : panda_risc_v_mul_pkg
//  Description : Shared types for the two-port multiplier arbiter: the
//                RISC-V multiply operation encoding and the arbiter FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package panda_risc_v_mul_pkg;

    // Multiply flavour as carried on the request and issue buses
    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_type_e;

    // Arbiter sequencing: one operation outstanding at a time
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } arb_state_e;

endpackage : panda_risc_v_mul_pkg
`default_nettype wire

// File: rtl/rr_arb_2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb_2
//  Description : Two-input round-robin arbiter. Purely combinational; a sole
//                requester always wins, a tie goes to the requester that was
//                not granted last. last_grant is the index (0/1) of that port.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot grant selection with fairness on ties
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule : rr_arb_2
`default_nettype wire

// File: rtl/panda_risc_v_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : panda_risc_v_mul_arbiter
//  Description : Shares one multiplier between two requesters. A request is
//                granted round-robin in IDLE, issued to the multiplier, its
//                result captured and handed back to the owner. Results that
//                arrive outside WAIT are dropped and flagged on proto_err.
//  Revision    : 1.0  initial release
// ============================================================================
module panda_risc_v_mul_arbiter
    import panda_risc_v_mul_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  s0_req_valid,
    output logic                  s0_req_ready,
    input  logic [DATA_WIDTH-1:0] s0_req_op_a,
    input  logic [DATA_WIDTH-1:0] s0_req_op_b,
    input  logic [1:0]            s0_req_type,
    output logic                  s0_res_valid,
    input  logic                  s0_res_ready,
    output logic [DATA_WIDTH-1:0] s0_res_data,

    input  logic                  s1_req_valid,
    output logic                  s1_req_ready,
    input  logic [DATA_WIDTH-1:0] s1_req_op_a,
    input  logic [DATA_WIDTH-1:0] s1_req_op_b,
    input  logic [1:0]            s1_req_type,
    output logic                  s1_res_valid,
    input  logic                  s1_res_ready,
    output logic [DATA_WIDTH-1:0] s1_res_data,

    output logic                  m_mul_req_valid,
    input  logic                  m_mul_req_ready,
    output logic [DATA_WIDTH-1:0] m_mul_op_a,
    output logic [DATA_WIDTH-1:0] m_mul_op_b,
    output logic [1:0]            m_mul_type,
    input  logic                  m_mul_res_valid,
    input  logic [DATA_WIDTH-1:0] m_mul_res_data,

    output logic                  busy,
    output logic                  proto_err
);

    arb_state_e            r_state;
    logic                  r_last_grant;
    logic                  r_owner;
    logic [DATA_WIDTH-1:0] r_op_a;
    logic [DATA_WIDTH-1:0] r_op_b;
    mul_type_e             r_type;
    logic [DATA_WIDTH-1:0] r_res_data;
    logic                  r_mul_req_valid;
    logic                  r_s0_res_valid;
    logic                  r_s1_res_valid;
    logic                  r_busy;
    logic                  r_proto_err;

    logic [1:0]            w_grant;
    logic                  w_idle;
    logic [DATA_WIDTH-1:0] w_sel_op_a;
    logic [DATA_WIDTH-1:0] w_sel_op_b;
    logic [1:0]            w_sel_type;
    logic                  w_owner_res_ready;

    rr_arb_2 u_rr_arb_2 (
        .req        ({s1_req_valid, s0_req_valid}),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    // Requests are only ever accepted in IDLE; ready follows the grant directly
    always_comb begin
        w_idle       = (r_state == IDLE);
        s0_req_ready = w_idle & w_grant[0];
        s1_req_ready = w_idle & w_grant[1];
    end

    // Operand mux for the winning requester and the owner's result handshake
    always_comb begin
        w_sel_op_a        = w_grant[1] ? s1_req_op_a : s0_req_op_a;
        w_sel_op_b        = w_grant[1] ? s1_req_op_b : s0_req_op_b;
        w_sel_type        = w_grant[1] ? s1_req_type : s0_req_type;
        w_owner_res_ready = r_owner ? s1_res_ready : s0_res_ready;
    end

    // Arbiter FSM with all handshake outputs and latched fields registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_last_grant    <= 1'b1;
            r_owner         <= 1'b0;
            r_op_a          <= '0;
            r_op_b          <= '0;
            r_type          <= MUL;
            r_res_data      <= '0;
            r_mul_req_valid <= 1'b0;
            r_s0_res_valid  <= 1'b0;
            r_s1_res_valid  <= 1'b0;
            r_busy          <= 1'b0;
            r_proto_err     <= 1'b0;
        end else begin
            // A result pulse is only legal while an issued op is in flight
            r_proto_err <= m_mul_res_valid && (r_state != WAIT);

            case (r_state)
                IDLE: begin
                    if (w_grant != 2'b00) begin
                        r_owner         <= w_grant[1];
                        r_op_a          <= w_sel_op_a;
                        r_op_b          <= w_sel_op_b;
                        r_type          <= mul_type_e'(w_sel_type);
                        r_mul_req_valid <= 1'b1;
                        r_busy          <= 1'b1;
                        r_state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_mul_req_ready) begin
                        r_mul_req_valid <= 1'b0;
                        r_state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (m_mul_res_valid) begin
                        r_res_data     <= m_mul_res_data;
                        r_s0_res_valid <= ~r_owner;
                        r_s1_res_valid <= r_owner;
                        r_state        <= RESP;
                    end
                end
                RESP: begin
                    if (w_owner_res_ready) begin
                        r_s0_res_valid <= 1'b0;
                        r_s1_res_valid <= 1'b0;
                        r_last_grant   <= r_owner;
                        r_busy         <= 1'b0;
                        r_state        <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Result data is only presented to the port that owns it
    always_comb begin
        s0_res_data = r_owner ? '0 : r_res_data;
        s1_res_data = r_owner ? r_res_data : '0;
    end

    assign s0_res_valid    = r_s0_res_valid;
    assign s1_res_valid    = r_s1_res_valid;
    assign m_mul_req_valid = r_mul_req_valid;
    assign m_mul_op_a      = r_op_a;
    assign m_mul_op_b      = r_op_b;
    assign m_mul_type      = r_type;
    assign busy            = r_busy;
    assign proto_err       = r_proto_err;

endmodule : panda_risc_v_mul_arbiter
`default_nettype wire

// File: tb/tb_panda_risc_v_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_panda_risc_v_mul_arbiter
//  Description : Directed self-checking bench for the two-port multiplier
//                arbiter; the multiplier side is driven by hand.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_panda_risc_v_mul_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s0_req_valid = 1'b0, s1_req_valid = 1'b0;
    logic          s0_req_ready, s1_req_ready;
    logic [DW-1:0] s0_req_op_a = '0, s0_req_op_b = '0, s1_req_op_a = '0, s1_req_op_b = '0;
    logic [1:0]    s0_req_type = 2'b00, s1_req_type = 2'b00;
    logic          s0_res_valid, s1_res_valid;
    logic          s0_res_ready = 1'b0, s1_res_ready = 1'b0;
    logic [DW-1:0] s0_res_data, s1_res_data;
    logic          m_mul_req_valid;
    logic          m_mul_req_ready = 1'b0;
    logic [DW-1:0] m_mul_op_a, m_mul_op_b;
    logic [1:0]    m_mul_type;
    logic          m_mul_res_valid = 1'b0;
    logic [DW-1:0] m_mul_res_data = '0;
    logic          busy, proto_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    panda_risc_v_mul_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_req_valid(s0_req_valid), .s0_req_ready(s0_req_ready),
        .s0_req_op_a(s0_req_op_a), .s0_req_op_b(s0_req_op_b), .s0_req_type(s0_req_type),
        .s0_res_valid(s0_res_valid), .s0_res_ready(s0_res_ready), .s0_res_data(s0_res_data),
        .s1_req_valid(s1_req_valid), .s1_req_ready(s1_req_ready),
        .s1_req_op_a(s1_req_op_a), .s1_req_op_b(s1_req_op_b), .s1_req_type(s1_req_type),
        .s1_res_valid(s1_res_valid), .s1_res_ready(s1_res_ready), .s1_res_data(s1_res_data),
        .m_mul_req_valid(m_mul_req_valid), .m_mul_req_ready(m_mul_req_ready),
        .m_mul_op_a(m_mul_op_a), .m_mul_op_b(m_mul_op_b), .m_mul_type(m_mul_type),
        .m_mul_res_valid(m_mul_res_valid), .m_mul_res_data(m_mul_res_data),
        .busy(busy), .proto_err(proto_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // From ISSUE: multiplier accepts, result after two WAIT cycles, owner takes it
    task automatic complete_op(input int owner, input logic [DW-1:0] product);
        m_mul_req_ready = 1'b1;
        tick();
        m_mul_req_ready = 1'b0;
        chk("wait_no_issue", m_mul_req_valid, 1'b0);
        tick();
        m_mul_res_valid = 1'b1;
        m_mul_res_data  = product;
        tick();
        m_mul_res_valid = 1'b0;
        m_mul_res_data  = '0;
        chk("resp_s0_valid", s0_res_valid, (owner == 0));
        chk("resp_s1_valid", s1_res_valid, (owner == 1));
        chk("resp_data", (owner == 0) ? s0_res_data : s1_res_data, product);
        if (owner == 0) s0_res_ready = 1'b1; else s1_res_ready = 1'b1;
        tick();
        s0_res_ready = 1'b0;
        s1_res_ready = 1'b0;
        chk("done_busy", busy, 1'b0);
        chk("done_s0_valid", s0_res_valid, 1'b0);
        chk("done_s1_valid", s1_res_valid, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] held_a;
        int            exp_owner;

        // ---------------- reset state ----------------
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_mreq", m_mul_req_valid, 1'b0);
        chk("rst_perr", proto_err, 1'b0);
        chk("rst_op_a", m_mul_op_a, 32'd0);
        chk("rst_s0res", s0_res_valid, 1'b0);
        rst_n = 1'b1;
        tick();

        // ---------------- single request: 3 x 5 ----------------
        s0_req_valid = 1'b1; s0_req_op_a = 32'd3; s0_req_op_b = 32'd5; s0_req_type = 2'b00;
        #1;
        chk("single_s0_ready", s0_req_ready, 1'b1);
        chk("single_s1_ready", s1_req_ready, 1'b0);
        tick();
        s0_req_valid = 1'b0;
        chk("single_issue_valid", m_mul_req_valid, 1'b1);
        chk("single_issue_a", m_mul_op_a, 32'd3);
        chk("single_issue_b", m_mul_op_b, 32'd5);
        chk("single_issue_type", m_mul_type, 2'b00);
        chk("single_busy", busy, 1'b1);
        tick();
        chk("single_still_issue", m_mul_req_valid, 1'b1);
        complete_op(0, 32'd15);

        // ---------------- contention after fresh reset ----------------
        rst_n = 1'b0; #2; rst_n = 1'b1;
        tick();
        s0_req_valid = 1'b1; s0_req_op_a = 32'd2; s0_req_op_b = 32'd7; s0_req_type = 2'b01;
        s1_req_valid = 1'b1; s1_req_op_a = 32'd4; s1_req_op_b = 32'd6; s1_req_type = 2'b10;
        for (int k = 0; k < 4; k++) begin
            exp_owner = k % 2;
            #1;
            chk("cont_s0_ready", s0_req_ready, (exp_owner == 0));
            chk("cont_s1_ready", s1_req_ready, (exp_owner == 1));
            tick();
            chk("cont_no_ready_issue", s0_req_ready | s1_req_ready, 1'b0);
            chk("cont_op_a", m_mul_op_a, (exp_owner == 0) ? 32'd2 : 32'd4);
            chk("cont_type", m_mul_type, (exp_owner == 0) ? 2'b01 : 2'b10);
            complete_op(exp_owner, (exp_owner == 0) ? 32'd14 : 32'd24);
        end
        s0_req_valid = 1'b0;
        s1_req_valid = 1'b0;
        tick();

        // ---------------- backpressure ----------------
        s1_req_valid = 1'b1; s1_req_op_a = 32'hFFFF_FFFF; s1_req_op_b = 32'd2; s1_req_type = 2'b11;
        #1;
        chk("bp_s1_ready", s1_req_ready, 1'b1);
        tick();
        s1_req_valid = 1'b0;
        held_a = 32'hFFFF_FFFF;
        for (int k = 0; k < 5; k++) begin
            chk("bp_issue_valid", m_mul_req_valid, 1'b1);
            chk("bp_issue_a", m_mul_op_a, held_a);
            chk("bp_issue_b", m_mul_op_b, 32'd2);
            chk("bp_issue_type", m_mul_type, 2'b11);
            tick();
        end
        m_mul_req_ready = 1'b1;
        tick();
        m_mul_req_ready = 1'b0;
        m_mul_res_valid = 1'b1; m_mul_res_data = 32'd1;
        tick();
        m_mul_res_valid = 1'b0; m_mul_res_data = '0;
        s0_req_valid = 1'b1; s0_req_op_a = 32'd9; s0_req_op_b = 32'd9; s0_req_type = 2'b00;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_res_valid", s1_res_valid, 1'b1);
            chk("bp_res_data", s1_res_data, 32'd1);
            chk("bp_no_grant", s0_req_ready, 1'b0);
            chk("bp_s0_res", s0_res_valid, 1'b0);
            tick();
        end
        s1_res_ready = 1'b1;
        tick();
        s1_res_ready = 1'b0;
        chk("bp_s1_released", s1_res_valid, 1'b0);
        chk("bp_s0_granted", s0_req_ready, 1'b1);
        tick();
        s0_req_valid = 1'b0;
        chk("bp_s0_issue_a", m_mul_op_a, 32'd9);
        complete_op(0, 32'd81);

        // ---------------- stray result in IDLE ----------------
        m_mul_res_valid = 1'b1; m_mul_res_data = 32'd99;
        tick();
        m_mul_res_valid = 1'b0; m_mul_res_data = '0;
        chk("stray_perr", proto_err, 1'b1);
        chk("stray_busy", busy, 1'b0);
        chk("stray_s0_res", s0_res_valid, 1'b0);
        chk("stray_s1_res", s1_res_valid, 1'b0);
        tick();
        chk("stray_perr_pulse", proto_err, 1'b0);
        chk("stray_idle", busy, 1'b0);

        // ---------------- reset during WAIT ----------------
        s1_req_valid = 1'b1; s1_req_op_a = 32'd6; s1_req_op_b = 32'd7; s1_req_type = 2'b00;
        tick();
        s1_req_valid = 1'b0;
        m_mul_req_ready = 1'b1;
        tick();
        m_mul_req_ready = 1'b0;
        chk("rw_in_wait", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rw_busy", busy, 1'b0);
        chk("rw_mreq", m_mul_req_valid, 1'b0);
        chk("rw_op_a", m_mul_op_a, 32'd0);
        chk("rw_s1_res", s1_res_valid, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        m_mul_res_valid = 1'b1; m_mul_res_data = 32'd42;
        tick();
        m_mul_res_valid = 1'b0; m_mul_res_data = '0;
        chk("rw_late_perr", proto_err, 1'b1);
        chk("rw_late_no_res", s1_res_valid, 1'b0);
        chk("rw_late_idle", busy, 1'b0);
        s1_req_valid = 1'b1;
        #1;
        chk("rw_s1_ready", s1_req_ready, 1'b1);
        tick();
        s1_req_valid = 1'b0;
        chk("rw_issue_a", m_mul_op_a, 32'd6);
        chk("rw_issue_b", m_mul_op_b, 32'd7);
        complete_op(1, 32'd42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_panda_risc_v_mul_arbiter
`default_nettype wire

// File: doc/panda_risc_v_mul_arbiter.md
PANDA_RISC_V_MUL_ARBITER -- requirements
Module: panda_risc_v_mul_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and result width.
REQ-002 Parameter: none further; requester count is fixed at 2 (N = 0, 1).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  the single clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 sN_req_valid  input  1  requester N has a multiply request.
REQ-007 sN_req_ready  output  1  requester N request accepted this cycle.
REQ-008 sN_req_op_a, sN_req_op_b  input  DATA_WIDTH  operands.
REQ-009 sN_req_type  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-010 sN_res_valid  output  1  result available for requester N.
REQ-011 sN_res_ready  input  1  requester N takes the result.
REQ-012 sN_res_data  output  DATA_WIDTH  result for requester N.
REQ-013 m_mul_req_valid  output  1  issue to the shared multiplier.
REQ-014 m_mul_req_ready  input  1  multiplier accepts the issue.
REQ-015 m_mul_op_a, m_mul_op_b  output  DATA_WIDTH; m_mul_type  output  2  issued operation.
REQ-016 m_mul_res_valid  input  1 and m_mul_res_data  input  DATA_WIDTH  are a one-cycle result pulse with no backpressure.
REQ-017 busy  output  1  high whenever the state is not IDLE.
REQ-018 proto_err  output  1  one-cycle pulse on an unexpected m_mul_res_valid.

Function
REQ-019 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP. Only one operation SHALL be outstanding at a time.
REQ-020 IDLE: if any sN_req_valid is high, grant exactly one requester round-robin. The requester not in last_grant wins a tie; a sole valid requester always wins.
REQ-021 In the grant cycle, the granted sN_req_ready SHALL be high (combinational from valid and state) and the other low. Operands, type and owner SHALL be latched, then go to ISSUE.
REQ-022 ISSUE: m_mul_req_valid=1 with the latched fields held stable. On m_mul_req_ready=1, go to WAIT in the next cycle.
REQ-023 WAIT: on m_mul_res_valid=1, latch m_mul_res_data and go to RESP.
REQ-024 RESP: owner's sN_res_valid=1 with held data; the non-owner's res_valid=0. On owner res_ready=1, go to IDLE and set last_grant=owner.
REQ-025 Minimum turnaround: 4 cycles plus multiplier latency. No request SHALL be accepted outside IDLE.
REQ-026 m_mul_res_valid in IDLE, ISSUE or RESP SHALL be ignored (data not latched) and SHALL pulse proto_err in the next cycle.
REQ-027 Operands and type SHALL pass unmodified. The arbiter does no arithmetic or sign handling.
REQ-028 A requester dropping req_valid before grant SHALL simply not be granted. Both valid in IDLE SHALL produce one grant only.

Reset
REQ-029 rst_n low SHALL asynchronously force the following:
- state=IDLE, last_grant=1 (s0 wins first);
- all ready/valid outputs, proto_err and busy low;
- latched data zero.
REQ-030 Reset mid-operation SHALL discard any in-flight request and result. A result pulse arriving after reset release, in IDLE, SHALL count as an unexpected result per REQ-026.

Structure
REQ-031 Package panda_risc_v_mul_pkg SHALL hold the mul_type enum (MUL/MULH/MULHSU/MULHU) and the FSM state enum.
REQ-032 The round-robin grant SHALL be the sub-module rr_arb_2: 2 requests, last_grant input, one-hot grant output, purely combinational.

Verification
REQ-033 Single request: s0 requests MUL, 3 x 5; model multiplier ready after 1 cycle, result after 3 cycles; s0_res_ready=1 -> s0_res_data=15; s1_res_valid never high.
REQ-034 Contention: s0 and s1 hold valid continuously -> grants alternate s0, s1, s0, s1 over 4 operations. The first grant goes to s0 after reset.
REQ-035 Backpressure: m_mul_req_ready low 5 cycles -> m_mul_* stable through ISSUE. s1_res_ready low 4 cycles -> s1_res_valid and data held; no new grant until the result is taken.
REQ-036 Stray result: m_mul_res_valid pulsed in IDLE -> proto_err one cycle, no res_valid, state stays IDLE.
REQ-037 Reset in WAIT: assert rst_n mid-operation -> outputs zero immediately. A later result pulse is ignored with proto_err. The next s1 request completes normally.
